// File: rtl/fll_ctrl_gen2_if.sv
// Control/status bundle between the FLL controller and its host:
// loop config, override values, VCO edge input and the DAC/corner/lock outputs.
interface fll_ctrl_gen2_if #(
   parameter int DAC_W    = 10,
   parameter int CORNER_W = 3,
   parameter int CNT_W    = 12
);
   logic                enable;
   logic                vco_edge;
   logic [CNT_W-1:0]    ref_time;
   logic [CNT_W-1:0]    upper;
   logic [CNT_W-1:0]    lower;
   logic                ovr_en;
   logic [DAC_W-1:0]    ovr_dac;
   logic [CORNER_W-1:0] ovr_corner;
   logic [DAC_W-1:0]    dac;
   logic [CORNER_W-1:0] corner;
   logic                lock;
   logic                rail;
   logic [CNT_W-1:0]    count_out;
   logic                count_valid;

   modport master (
      output enable, vco_edge, ref_time, upper, lower, ovr_en, ovr_dac, ovr_corner,
      input  dac, corner, lock, rail, count_out, count_valid
   );
   modport slave (
      input  enable, vco_edge, ref_time, upper, lower, ovr_en, ovr_dac, ovr_corner,
      output dac, corner, lock, rail, count_out, count_valid
   );
endinterface

// File: rtl/fll_ctrl_gen2.sv
// FLL controller: counts VCO edges per reference window, SAR coarse search on the DAC,
// then +/-1 tracking with automatic corner stepping and hysteretic lock.
module fll_ctrl_gen2 #(
   parameter int DAC_W    = 10,
   parameter int CORNER_W = 3,
   parameter int CNT_W    = 12,
   parameter int LOCK_N   = 4,
   parameter int UNLOCK_N = 2,
   parameter int SETTLE   = 4
) (
   input  logic              clk,
   input  logic              reset,
   fll_ctrl_gen2_if.slave    bus
);
   localparam int IW = (DAC_W > 1) ? $clog2(DAC_W) : 1;
   localparam int LW = $clog2(LOCK_N + 1);
   localparam int UW = $clog2(UNLOCK_N + 1);
   localparam logic [DAC_W-1:0]    DAC_MID    = {1'b1, {(DAC_W-1){1'b0}}};
   localparam logic [DAC_W-1:0]    DAC_MAX    = {DAC_W{1'b1}};
   localparam logic [CORNER_W-1:0] CORNER_MID = {1'b1, {(CORNER_W-1){1'b0}}};
   localparam logic [CORNER_W-1:0] CORNER_MAX = {CORNER_W{1'b1}};
   localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]    SETTLE_LD  = CNT_W'(SETTLE - 1);
   localparam logic [LW-1:0]       LOCK_C     = LW'(LOCK_N);
   localparam logic [UW-1:0]       UNLOCK_C   = UW'(UNLOCK_N);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_EVAL} state_t;

   state_t              state_q, state_d;
   logic                search_q, search_d;
   logic [IW-1:0]       bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [DAC_W-1:0]    dac_q, dac_d;
   logic [CORNER_W-1:0] corner_q, corner_d;
   logic                lock_q, lock_d;
   logic                rail_q, rail_d;
   logic [CNT_W-1:0]    count_out_q, count_out_d;
   logic                count_valid_q, count_valid_d;
   logic [LW-1:0]       in_cnt_q, in_cnt_d, in_nxt;
   logic [UW-1:0]       out_cnt_q, out_cnt_d, out_nxt;
   logic [IW-1:0]       idx_m1;
   logic                fast, slow, restart;

   assign idx_m1 = bit_idx_q - 1'b1;

   always_comb begin
      state_d       = state_q;
      search_d      = search_q;
      bit_idx_d     = bit_idx_q;
      timer_d       = timer_q;
      count_d       = count_q;
      dac_d         = dac_q;
      corner_d      = corner_q;
      lock_d        = lock_q;
      rail_d        = rail_q;
      count_out_d   = count_out_q;
      count_valid_d = 1'b0;
      in_cnt_d      = in_cnt_q;
      out_cnt_d     = out_cnt_q;
      restart       = 1'b0;
      // upper < lower is legal config: fast wins
      fast    = count_q > bus.upper;
      slow    = !fast && (count_q < bus.lower);
      in_nxt  = (in_cnt_q == LOCK_C) ? in_cnt_q : in_cnt_q + 1'b1;
      out_nxt = (out_cnt_q == UNLOCK_C) ? out_cnt_q : out_cnt_q + 1'b1;

      if (bus.ovr_en) begin
         state_d   = S_IDLE;
         dac_d     = bus.ovr_dac;
         corner_d  = bus.ovr_corner;
         lock_d    = 1'b0;
         in_cnt_d  = '0;
         out_cnt_d = '0;
      end else if (!bus.enable) begin
         // window in flight is dropped; dac/corner hold
         state_d   = S_IDLE;
         lock_d    = 1'b0;
         in_cnt_d  = '0;
         out_cnt_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_SETTLE;
               timer_d = SETTLE_LD;
               restart = 1'b1;
            end
            S_SETTLE: begin
               if (timer_q == '0) begin
                  state_d = S_MEASURE;
                  timer_d = (bus.ref_time == '0) ? '0 : bus.ref_time - 1'b1;
                  count_d = '0;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            S_MEASURE: begin
               if (bus.vco_edge && count_q != CNT_MAX) count_d = count_q + 1'b1;
               if (timer_q == '0) state_d = S_EVAL;
               else               timer_d = timer_q - 1'b1;
            end
            S_EVAL: begin
               state_d       = S_SETTLE;
               timer_d       = SETTLE_LD;
               count_out_d   = count_q;
               count_valid_d = 1'b1;
               if (search_q) begin
                  if (fast) dac_d[bit_idx_q] = 1'b0;
                  if (bit_idx_q != '0) begin
                     dac_d[idx_m1] = 1'b1;
                     bit_idx_d     = idx_m1;
                  end else begin
                     search_d = 1'b0;
                  end
               end else begin
                  rail_d = 1'b0;
                  if (!fast && !slow) begin
                     in_cnt_d  = in_nxt;
                     out_cnt_d = '0;
                     if (in_nxt == LOCK_C) lock_d = 1'b1;
                  end else begin
                     out_cnt_d = out_nxt;
                     in_cnt_d  = '0;
                     if (out_nxt == UNLOCK_C) lock_d = 1'b0;
                  end
                  if (fast) begin
                     if (dac_q != '0)           dac_d = dac_q - 1'b1;
                     else if (corner_q != '0) begin
                        corner_d = corner_q - 1'b1;
                        restart  = 1'b1;
                     end else                   rail_d = 1'b1;
                  end else if (slow) begin
                     if (dac_q != DAC_MAX)      dac_d = dac_q + 1'b1;
                     else if (corner_q != CORNER_MAX) begin
                        corner_d = corner_q + 1'b1;
                        restart  = 1'b1;
                     end else                   rail_d = 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
         if (restart) begin
            search_d  = 1'b1;
            bit_idx_d = IW'(DAC_W - 1);
            dac_d     = DAC_MID;
            lock_d    = 1'b0;
            in_cnt_d  = '0;
            out_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         search_q      <= 1'b1;
         bit_idx_q     <= IW'(DAC_W - 1);
         timer_q       <= '0;
         count_q       <= '0;
         dac_q         <= DAC_MID;
         corner_q      <= CORNER_MID;
         lock_q        <= 1'b0;
         rail_q        <= 1'b0;
         count_out_q   <= '0;
         count_valid_q <= 1'b0;
         in_cnt_q      <= '0;
         out_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         search_q      <= search_d;
         bit_idx_q     <= bit_idx_d;
         timer_q       <= timer_d;
         count_q       <= count_d;
         dac_q         <= dac_d;
         corner_q      <= corner_d;
         lock_q        <= lock_d;
         rail_q        <= rail_d;
         count_out_q   <= count_out_d;
         count_valid_q <= count_valid_d;
         in_cnt_q      <= in_cnt_d;
         out_cnt_q     <= out_cnt_d;
      end
   end

   assign bus.dac         = dac_q;
   assign bus.corner      = corner_q;
   assign bus.lock        = lock_q;
   assign bus.rail        = rail_q;
   assign bus.count_out   = count_out_q;
   assign bus.count_valid = count_valid_q;
endmodule
